vga_sync_gen: RTL and testbench

- Timing generator directly upstream of the Pong pixel/object generator; produces video_on and pixel_x/pixel_y for the object renderer.
- Produces active-low hsync/vsync for the VGA connector.
- Default timing: 640x480 @ 60 Hz from a 100 MHz system clock, using a divide-by-4 pixel tick.

---
 rtl/vga_sync_gen.sv | 124 ++++++++++++
 tb/tb_vga_sync_gen.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, horizontal/vertical counters,
// registered active-low syncs. Optional frame pulse/counter via VGA_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic       frame_tick,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_DISP   = 10'(H_DISPLAY);
  localparam logic [9:0] V_DISP   = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_hsync;
  logic             r_vsync;

  logic             w_tick;
  logic             w_h_end;
  logic             w_v_end;
  logic [9:0]       w_x_next;
  logic [9:0]       w_y_next;

  assign w_tick  = (r_div == DIV_LAST);
  assign w_h_end = (r_x == H_LAST);
  assign w_v_end = (r_y == V_LAST);

  // Next-state counters feed both the counter registers and the sync decode,
  // so syncs change on the very edge the counters do.
  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (w_tick) begin
      if (w_h_end) begin
        w_x_next = '0;
        if (w_v_end) begin
          w_y_next = '0;
        end else if (r_y < V_LAST) begin
          w_y_next = r_y + 10'd1;
        end
      end else if (r_x < H_LAST) begin
        w_x_next = r_x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else begin
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_hsync <= ~((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST));
      r_vsync <= ~((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST));
    end
  end

  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign p_tick   = w_tick;
  assign pixel_x  = r_x;
  assign pixel_y  = r_y;
  assign video_on = (r_x < H_DISP) && (r_y < V_DISP);

`ifdef VGA_FRAME_CNT_EN
  logic       r_frame_tick;
  logic [7:0] r_frame_cnt;
  logic       w_frame_wrap;

  assign w_frame_wrap = w_tick && w_h_end && w_v_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_tick <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign frame_tick = r_frame_tick;
  assign frame_cnt  = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen using a shrunken raster (30x17, /4) so whole
// frames fit in a short run. Frame counter checks are built with VGA_FRAME_CNT_EN.
module tb_vga_sync_gen;

  localparam int CLK_DIV   = 4;
  localparam int H_DISPLAY = 16;
  localparam int H_FRONT   = 4;
  localparam int H_SYNC    = 6;
  localparam int H_BACK    = 4;
  localparam int V_DISPLAY = 10;
  localparam int V_FRONT   = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 3;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;  // 30
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;  // 17
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;           // 2040

  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_params
    initial $fatal(1, "illegal timing parameters: total exceeds 1024");
  end

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
`ifdef VGA_FRAME_CNT_EN
  logic       frame_tick;
  logic [7:0] frame_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  vga_sync_gen #(
    .CLK_DIV(CLK_DIV), .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT),
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .V_DISPLAY(V_DISPLAY),
    .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .p_tick(p_tick),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_tick(frame_tick),
    .frame_cnt(frame_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_xy(input logic [9:0] x, input logic [9:0] y, input int budget);
    int n;
    n = 0;
    while (!(pixel_x == x && pixel_y == y) && n < budget) begin
      tick();
      n++;
    end
    check("wait_xy_reached", {31'd0, (pixel_x == x && pixel_y == y)}, 32'd1);
  endtask

  initial begin
    int n;
    int pt_cnt;
    int von_cnt;
    int von_bad;
    int vs_low;
    int vs_bad;
    int hs_bad;
    int hs_falls;
    logic prev_hs;
    logic [9:0] px;
    logic [9:0] py;

    // 1: reset, divider phase
    reset = 1'b1;
    repeat (3) tick();
    check("rst_x", pixel_x, 0);
    check("rst_y", pixel_y, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_video_on", video_on, 1);
    check("rst_p_tick", p_tick, 0);
    reset = 1'b0;
    pt_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("p_tick_phase", p_tick, (k % 4 == 2) ? 1 : 0);
    end
    check("x_after_12clk", pixel_x, 3);
    for (int k = 0; k < 40; k++) begin
      tick();
      if (p_tick) pt_cnt++;
    end
    check("p_tick_count_40", pt_cnt, 10);

    // 2: end of visible line, hsync window
    wait_xy(10'd15, 10'd0, 200);
    check("von_last_visible", video_on, 1);
    repeat (4) tick();
    check("x_first_blank", pixel_x, 16);
    check("von_first_blank", video_on, 0);
    check("hsync_front_porch", hsync, 1);
    wait_xy(10'd19, 10'd0, 200);
    check("hsync_before_pulse", hsync, 1);
    repeat (4) tick();
    check("x_hsync_start", pixel_x, 20);
    check("hsync_fell", hsync, 0);
    n = 0;
    while (hsync == 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check("hsync_low_clks", n, 24);
    check("x_hsync_end", pixel_x, 26);

    // 3: line and frame wrap
    wait_xy(10'd29, 10'd0, 200);
    repeat (4) tick();
    check("line_wrap_x", pixel_x, 0);
    check("line_wrap_y", pixel_y, 1);
    wait_xy(10'd29, 10'd16, 2 * FRAME_CLKS);
    repeat (4) tick();
    check("frame_wrap_x", pixel_x, 0);
    check("frame_wrap_y", pixel_y, 0);
    n = 0;
    px = pixel_x;
    py = pixel_y;
    while (n < 3 * FRAME_CLKS) begin
      tick();
      n++;
      if (pixel_x == 0 && pixel_y == 0 && !(px == 0 && py == 0)) break;
      px = pixel_x;
      py = pixel_y;
    end
    check("frame_period_clks", n, FRAME_CLKS);

    // 4: one full frame sweep of sync/blank windows
    von_cnt = 0; von_bad = 0; vs_low = 0; vs_bad = 0; hs_bad = 0; hs_falls = 0;
    prev_hs = hsync;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      if (video_on) von_cnt++;
      if (video_on && pixel_y >= 10) von_bad++;
      if (!vsync) vs_low++;
      if (vsync !== ((pixel_y == 12 || pixel_y == 13) ? 1'b0 : 1'b1)) vs_bad++;
      if (hsync !== ((pixel_x >= 20 && pixel_x <= 25) ? 1'b0 : 1'b1)) hs_bad++;
      if (!vsync && prev_hs && !hsync) hs_falls++;
      prev_hs = hsync;
      tick();
    end
    check("von_clks_per_frame", von_cnt, 640);
    check("von_in_vblank", von_bad, 0);
    check("vsync_low_clks", vs_low, 240);
    check("vsync_window", vs_bad, 0);
    check("hsync_window", hs_bad, 0);
    check("hsync_pulses_in_vsync", hs_falls, 2);

    // 5: mid-frame reset, including during hsync pulse
    wait_xy(10'd10, 10'd5, 2 * FRAME_CLKS);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_x", pixel_x, 0);
    check("midrst_y", pixel_y, 0);
    check("midrst_p_tick", p_tick, 0);
    tick();
    check("midrst_p_tick_1", p_tick, 0);
    tick();
    check("midrst_p_tick_2", p_tick, 0);
    tick();
    check("midrst_p_tick_3", p_tick, 1);
    wait_xy(10'd22, 10'd12, 2 * FRAME_CLKS);
    check("pre_rst_hsync_low", hsync, 0);
    check("pre_rst_vsync_low", vsync, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_in_sync_hsync", hsync, 1);
    check("rst_in_sync_vsync", vsync, 1);
    check("rst_in_sync_x", pixel_x, 0);

`ifdef VGA_FRAME_CNT_EN
    // 6: frame pulse and counter
    begin
      int pulses;
      int last_at;
      int width_bad;
      int gap_bad;
      logic prev_ft;
      reset = 1'b1;
      tick();
      check("rst_frame_tick", frame_tick, 0);
      check("rst_frame_cnt", frame_cnt, 0);
      reset = 1'b0;
      pulses = 0; last_at = -1; width_bad = 0; gap_bad = 0; prev_ft = 1'b0;
      for (int i = 0; i < 3 * FRAME_CLKS + 10; i++) begin
        tick();
        if (frame_tick && prev_ft) width_bad++;
        if (frame_tick) begin
          if (last_at >= 0 && (i - last_at) != FRAME_CLKS) gap_bad++;
          last_at = i;
          pulses++;
        end
        prev_ft = frame_tick;
      end
      check("frame_pulses", pulses, 3);
      check("frame_pulse_width", width_bad, 0);
      check("frame_pulse_gap", gap_bad, 0);
      check("frame_cnt_3", frame_cnt, 3);
      force dut.r_frame_cnt = 8'd255;
      tick();
      release dut.r_frame_cnt;
      tick();
      check("frame_cnt_preload", frame_cnt, 255);
      n = 0;
      while (!frame_tick && n < 2 * FRAME_CLKS) begin
        tick();
        n++;
      end
      check("frame_tick_after_preload", frame_tick, 1);
      check("frame_cnt_wrap", frame_cnt, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
